// File: rtl/uart_pkg.sv
// Shared UART definitions: sequencer state encoding, line configuration
// encodings common to the TX/RX units, and a counter width helper.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        WAIT_DONE,
        GAP
    } tx_seq_state_e;

    typedef enum logic [1:0] {
        PARITY_NONE  = 2'b00,
        PARITY_ODD   = 2'b01,
        PARITY_EVEN  = 2'b10,
        PARITY_STICK = 2'b11
    } parity_type_e;

    typedef enum logic [1:0] {
        BAUD_4800  = 2'b00,
        BAUD_9600  = 2'b01,
        BAUD_19200 = 2'b10,
        BAUD_38400 = 2'b11
    } baud_rate_e;

    typedef struct packed {
        parity_type_e parity_type;
        baud_rate_e   baud_rate;
    } line_cfg_t;

    localparam line_cfg_t LINE_CFG_RESET = '{parity_type: PARITY_NONE, baud_rate: BAUD_4800};

    // Bits needed to count 0..max_val-1 (at least one bit).
    function automatic int cnt_width(input int max_val);
        return (max_val < 2) ? 1 : $clog2(max_val);
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock FIFO with flush; the head entry is visible combinationally so
// the consumer can register it in the same cycle it pops.
module uart_sync_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8
) (
    input  logic                     clock_i,
    input  logic                     reset_n_i,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   level_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic                     overflow_o
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      level_q, level_d;
    logic             push_ok, pop_ok;

    assign full_o  = (level_q == FULL_LEVEL);
    assign empty_o = (level_q == '0);
    assign level_o = level_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees the slot the same cycle, so push+pop while full is legal.
    assign pop_ok     = pop_i & ~empty_o & ~flush_i;
    assign push_ok    = push_i & (~full_o | pop_ok) & ~flush_i;
    assign overflow_o = push_i & full_o & ~pop_ok & ~flush_i;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + (AW+1)'(1);
                2'b01:   level_d = level_q - (AW+1)'(1);
                default: level_d = level_q;
            endcase
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    always_ff @(posedge clock_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// Feeds buffered bytes to the TX unit one frame at a time and owns the line
// configuration, which is only ever switched while no frame is in progress.
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int FIFO_DEPTH    = 16,
    parameter int GAP_CYCLES    = 2,
    parameter int START_TIMEOUT = 4096
) (
    input  logic                          clock_i,
    input  logic                          reset_n_i,
    input  logic                          wr_en_i,
    input  logic [7:0]                    wr_data_i,
    input  logic                          tx_enable_i,
    input  logic                          flush_i,
    input  logic                          cfg_update_i,
    input  logic [1:0]                    cfg_parity_type_i,
    input  logic [1:0]                    cfg_baud_rate_i,
    input  logic                          tx_active_flag_i,
    input  logic                          tx_done_flag_i,
    output logic                          tx_send_o,
    output logic [7:0]                    tx_data_o,
    output logic [1:0]                    tx_parity_type_o,
    output logic [1:0]                    tx_baud_rate_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level_o,
    output logic                          fifo_full_o,
    output logic                          fifo_empty_o,
    output logic                          busy_o,
    output logic                          overflow_err_o,
    output logic                          timeout_err_o
);

    localparam int CNT_MAX = (START_TIMEOUT > GAP_CYCLES) ? START_TIMEOUT : GAP_CYCLES;
    localparam int CNT_W   = cnt_width(CNT_MAX);
    localparam logic [CNT_W-1:0] START_LAST = CNT_W'(START_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    tx_seq_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       tx_data_q, tx_data_d;
    line_cfg_t        cfg_q, cfg_d;
    line_cfg_t        pend_cfg_q, pend_cfg_d;
    logic             pend_valid_q, pend_valid_d;
    logic             overflow_q, overflow_d;
    logic             timeout_q, timeout_d;
    logic             fifo_pop, fifo_empty, fifo_overflow;
    logic [7:0]       fifo_head;

    // Flags arrive from the baud-clock domain: two-flop synchronisers, bit0=active, bit1=done.
    logic [1:0] flag_raw, flag_s;
    assign flag_raw = {tx_done_flag_i, tx_active_flag_i};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic [1:0] ff_q;
            always_ff @(posedge clock_i or negedge reset_n_i) begin
                if (!reset_n_i) ff_q <= 2'b00;
                else            ff_q <= {ff_q[0], flag_raw[gi]};
            end
            assign flag_s[gi] = ff_q[1];
        end
    endgenerate

    logic act_s, done_s;
    assign act_s  = flag_s[0];
    assign done_s = flag_s[1];

    uart_sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clock_i    (clock_i),
        .reset_n_i  (reset_n_i),
        .push_i     (wr_en_i),
        .pop_i      (fifo_pop),
        .flush_i    (flush_i),
        .wr_data_i  (wr_data_i),
        .head_o     (fifo_head),
        .level_o    (fifo_level_o),
        .full_o     (fifo_full_o),
        .empty_o    (fifo_empty),
        .overflow_o (fifo_overflow)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        tx_data_d    = tx_data_q;
        cfg_d        = cfg_q;
        pend_cfg_d   = pend_cfg_q;
        pend_valid_d = pend_valid_q;
        overflow_d   = overflow_q | fifo_overflow;
        timeout_d    = timeout_q;
        fifo_pop     = 1'b0;

        case (state_q)
            IDLE: begin
                if (pend_valid_q) begin
                    cfg_d        = pend_cfg_q;
                    pend_valid_d = 1'b0;
                end else if (tx_enable_i && !fifo_empty) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                // A flush racing the load empties the FIFO; abandon the frame.
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    fifo_pop  = 1'b1;
                    tx_data_d = fifo_head;
                    cnt_d     = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (act_s) begin
                    state_d = WAIT_DONE;
                end else if (cnt_q == START_LAST) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            WAIT_DONE: begin
                if (!act_s && done_s) begin
                    cnt_d   = '0;
                    state_d = (GAP_CYCLES == 0) ? IDLE : GAP;
                end
            end
            GAP: begin
                if (cnt_q == GAP_LAST) state_d = IDLE;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = IDLE;
        endcase

        // Capture after the apply above so a request in the apply cycle stays pending.
        if (cfg_update_i) begin
            pend_cfg_d.parity_type = parity_type_e'(cfg_parity_type_i);
            pend_cfg_d.baud_rate   = baud_rate_e'(cfg_baud_rate_i);
            pend_valid_d           = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            tx_data_q    <= '0;
            cfg_q        <= LINE_CFG_RESET;
            pend_cfg_q   <= LINE_CFG_RESET;
            pend_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            tx_data_q    <= tx_data_d;
            cfg_q        <= cfg_d;
            pend_cfg_q   <= pend_cfg_d;
            pend_valid_q <= pend_valid_d;
            overflow_q   <= overflow_d;
            timeout_q    <= timeout_d;
        end
    end

    // Decoded from the state register so reset removes the request immediately.
    assign tx_send_o        = (state_q == START);
    assign busy_o           = (state_q != IDLE);
    assign tx_data_o        = tx_data_q;
    assign tx_parity_type_o = cfg_q.parity_type;
    assign tx_baud_rate_o   = cfg_q.baud_rate;
    assign fifo_empty_o     = fifo_empty;
    assign overflow_err_o   = overflow_q;
    assign timeout_err_o    = timeout_q;

endmodule
